// File: rtl/btn_sequence_unit_pkg.sv
// btn_seq_pkg: button indices, FSM states, unlock sequence and stage codes
package btn_seq_pkg;
  localparam int BTN_L = 0;
  localparam int BTN_D = 1;
  localparam int BTN_R = 2;
  localparam int BTN_C = 3;
  localparam int BTN_U = 4;
  localparam logic [4:0] LDR_MASK = 5'b11111 & ~((5'(1) << BTN_C) | (5'(1) << BTN_U));
  localparam int SEQ [0:2] = '{BTN_D, BTN_L, BTN_R};
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_D = 3'd1,
    S_WAIT_L = 3'd2,
    S_WAIT_R = 3'd3,
    S_DONE   = 3'd4
  } state_t;
  localparam logic [1:0] STG_WAIT_D = 2'd0;
  localparam logic [1:0] STG_WAIT_L = 2'd1;
  localparam logic [1:0] STG_WAIT_R = 2'd2;
  localparam logic [1:0] STG_DONE   = 2'd3;
  function automatic logic [1:0] stage_of(state_t s);
    return s == S_WAIT_L ? STG_WAIT_L : s == S_WAIT_R ? STG_WAIT_R : s == S_DONE ? STG_DONE : STG_WAIT_D;
  endfunction
endpackage

// File: rtl/btn_sequence_unit_if.sv
// btn_sequence_unit_if: buttons in, press pulses and sequence progress out
interface btn_sequence_unit_if;
  logic       arm;
  logic [4:0] btn_raw;
  logic [4:0] press;
  logic [1:0] stage;
  logic       done;
  logic       err;
  modport master (output arm, btn_raw, input press, stage, done, err);
  modport slave (input arm, btn_raw, output press, stage, done, err);
endinterface

// File: rtl/btn_sequence_unit_debounce.sv
// btn_debounce: two-flop sync, stable-count debounce and registered rising-edge pulse for one button
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_press
);
  logic r_s1, r_s2, r_db, r_db_d, r_press;
  logic [DB_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
      r_db_d <= 1'b0;
      r_press <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_db_d <= r_db;
      r_press <= r_db & ~r_db_d;
      if (r_s2 == r_db) r_cnt <= '0;
      else if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
        r_db <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_press = r_press;
endmodule

// File: rtl/btn_sequence_unit.sv
// btn_sequence_unit: debounced button pulses and D->L->R unlock tracker; BTN_SEQ_TIMEOUT_EN adds a per-step timeout
module btn_sequence_unit
  import btn_seq_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W = 20
`ifdef BTN_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 500_000_000
`endif
) (
  input logic clk,
  input logic rst,
  btn_sequence_unit_if.slave bus
);
  state_t r_state;
  state_t w_adv;
  logic [1:0] r_stage, w_step;
  logic r_done, r_err;
  logic [4:0] w_press, w_exp, w_ldr;
  logic w_valid, w_wrong, w_tmo, w_in_lr;
  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
      .clk(clk), .rst(rst), .i_raw(bus.btn_raw[g]), .o_press(w_press[g])
    );
  end
  assign w_in_lr = r_state == S_WAIT_L || r_state == S_WAIT_R;
  assign w_step = r_state == S_WAIT_L ? 2'd1 : r_state == S_WAIT_R ? 2'd2 : 2'd0;
  assign w_exp = 5'(1) << SEQ[w_step];
  assign w_ldr = w_press & LDR_MASK;
  assign w_valid = w_ldr == w_exp;
  assign w_wrong = w_ldr != '0 && !w_valid;
  assign w_adv = r_state == S_WAIT_D ? S_WAIT_L : r_state == S_WAIT_L ? S_WAIT_R : S_DONE;
`ifdef BTN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  // restarts on every step advance so each of WAIT_L/WAIT_R gets a full window
  always_ff @(posedge clk) begin
    if (rst || !w_in_lr || w_valid) r_tmo <= '0;
    else r_tmo <= r_tmo + 1'b1;
  end
  assign w_tmo = w_in_lr && r_tmo == TW'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst || !bus.arm) begin
      r_state <= S_IDLE;
      r_stage <= STG_WAIT_D;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_state <= S_WAIT_D;
      r_err <= 1'b0;
    end else if (r_state != S_DONE && w_valid) begin
      r_state <= w_adv;
      r_stage <= stage_of(w_adv);
      r_done <= w_adv == S_DONE;
      r_err <= 1'b0;
    end else if (r_state != S_DONE && (w_wrong || w_tmo)) begin
      r_state <= S_WAIT_D;
      r_stage <= STG_WAIT_D;
      r_err <= 1'b1;
    end else r_err <= 1'b0;
  end
  assign bus.press = w_press;
  assign bus.stage = r_stage;
  assign bus.done = r_done;
  assign bus.err = r_err;
endmodule

// File: tb/tb_btn_sequence_unit.sv
// tb_btn_sequence_unit: directed checks of debounce, press latency and unlock sequence tracking
module tb_btn_sequence_unit;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  btn_sequence_unit_if bus ();
  btn_sequence_unit #(
    .DB_CYCLES(4), .DB_W(3)
`ifdef BTN_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tap(input logic [4:0] m, output int lat, output int np, output int errat, output int ne);
    lat = 0; np = 0; errat = 0; ne = 0;
    bus.btn_raw = m;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if ((bus.press & m) != 5'b0) begin np++; if (lat == 0) lat = k; end
      if (bus.err) begin ne++; if (errat == 0) errat = k; end
      if (k == 10) bus.btn_raw = 5'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.arm = 1'b0; bus.btn_raw = 5'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.press !== 5'b0) begin n_fail++; $display("FAIL reset_press: got %b want 00000", bus.press); end
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL reset_stage: got %0d want 0", bus.stage); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_chk++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bounce;
    int np = 0, lat = 0, ne = 0;
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw[1] = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        if (bus.press[1]) np++;
        if (bus.err) ne++;
      end
    end
    bus.btn_raw[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.press[1]) begin np++; if (lat == 0) lat = k; end
    end
    bus.btn_raw[1] = 1'b0;
    repeat (16) begin @(negedge clk); if (bus.press[1]) np++; end
    n_chk++; if (np !== 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 1", np); end
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL bounce_latency: got %0d want 7", lat); end
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL bounce_err: got %0d want 0", ne); end
  endtask

  task automatic test_happy;
    int lat, np, errat, ne, tot;
    tot = 0;
    bus.arm = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL happy_armed_stage: got %0d want 0", bus.stage); end
    tap(5'b00010, lat, np, errat, ne); tot += ne;
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL happy_d_latency: got %0d want 7", lat); end
    n_chk++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL happy_stage1: got %0d want 1", bus.stage); end
    tap(5'b00001, lat, np, errat, ne); tot += ne;
    n_chk++; if (bus.stage !== 2'd2) begin n_fail++; $display("FAIL happy_stage2: got %0d want 2", bus.stage); end
    tap(5'b00100, lat, np, errat, ne); tot += ne;
    n_chk++; if (bus.stage !== 2'd3) begin n_fail++; $display("FAIL happy_stage3: got %0d want 3", bus.stage); end
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL happy_done: got %b want 1", bus.done); end
    n_chk++; if (tot !== 0) begin n_fail++; $display("FAIL happy_err: got %0d want 0", tot); end
    tap(5'b00010, lat, np, errat, ne);
    n_chk++; if (np !== 1) begin n_fail++; $display("FAIL done_press_pulse: got %0d want 1", np); end
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL done_press_err: got %0d want 0", ne); end
    n_chk++; if (bus.stage !== 2'd3) begin n_fail++; $display("FAIL done_sticky: got %0d want 3", bus.stage); end
  endtask

  task automatic test_disarm;
    int lat, np, errat, ne;
    bus.arm = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL disarm_done: got %b want 0", bus.done); end
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL disarm_stage: got %0d want 0", bus.stage); end
    tap(5'b00100, lat, np, errat, ne);
    n_chk++; if (np !== 1) begin n_fail++; $display("FAIL idle_press_pulse: got %0d want 1", np); end
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL idle_press_err: got %0d want 0", ne); end
  endtask

  task automatic test_wrong;
    int lat, np, errat, ne, tot;
    bus.arm = 1'b1;
    repeat (2) @(negedge clk);
    tap(5'b00010, lat, np, errat, ne);
    n_chk++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL wrong_stage1: got %0d want 1", bus.stage); end
    tap(5'b00100, lat, np, errat, ne);
    n_chk++; if (errat !== 8) begin n_fail++; $display("FAIL wrong_err_cycle: got %0d want 8", errat); end
    n_chk++; if (ne !== 1) begin n_fail++; $display("FAIL wrong_err_count: got %0d want 1", ne); end
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL wrong_stage0: got %0d want 0", bus.stage); end
    tap(5'b00010, lat, np, errat, ne); tot = ne;
    tap(5'b00001, lat, np, errat, ne); tot += ne;
    tap(5'b00100, lat, np, errat, ne); tot += ne;
    n_chk++; if (bus.stage !== 2'd3) begin n_fail++; $display("FAIL wrong_recover_stage: got %0d want 3", bus.stage); end
    n_chk++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wrong_recover_done: got %b want 1", bus.done); end
    n_chk++; if (tot !== 0) begin n_fail++; $display("FAIL wrong_recover_err: got %0d want 0", tot); end
    bus.arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous;
    int lat, np, errat, ne;
    bus.arm = 1'b1;
    repeat (2) @(negedge clk);
    tap(5'b00010, lat, np, errat, ne);
    tap(5'b01000, lat, np, errat, ne);
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL sim_c_err: got %0d want 0", ne); end
    n_chk++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL sim_c_stage: got %0d want 1", bus.stage); end
    tap(5'b00101, lat, np, errat, ne);
    n_chk++; if (errat !== 8) begin n_fail++; $display("FAIL sim_lr_err_cycle: got %0d want 8", errat); end
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL sim_lr_stage: got %0d want 0", bus.stage); end
    bus.arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_held;
    int np = 0, lat = 0;
    bus.btn_raw = 5'b00001;
    rst = 1'b1;
    repeat (12) begin @(negedge clk); if (bus.press[0]) np++; end
    n_chk++; if (np !== 0) begin n_fail++; $display("FAIL held_rst_press: got %0d want 0", np); end
    n_chk++; if ({bus.stage, bus.done, bus.err} !== 4'b0) begin n_fail++; $display("FAIL held_rst_outputs: got %b want 0000", {bus.stage, bus.done, bus.err}); end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.press[0]) begin np++; if (lat == 0) lat = k; end
    end
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL held_press_latency: got %0d want 7", lat); end
    n_chk++; if (np !== 1) begin n_fail++; $display("FAIL held_press_count: got %0d want 1", np); end
    bus.btn_raw = 5'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat, np, errat, ne;
    bus.arm = 1'b1;
    repeat (2) @(negedge clk);
    tap(5'b00010, lat, np, errat, ne);
    n_chk++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL tmo_stage1: got %0d want 1", bus.stage); end
    errat = 0; ne = 0;
`ifdef BTN_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.err && errat == 0) errat = k;
    end
    n_chk++; if (errat !== 34) begin n_fail++; $display("FAIL tmo_err_cycle: got %0d want 34", errat); end
    n_chk++; if (bus.stage !== 2'd0) begin n_fail++; $display("FAIL tmo_stage0: got %0d want 0", bus.stage); end
`else
    repeat (60) begin @(negedge clk); if (bus.err) ne++; end
    n_chk++; if (ne !== 0) begin n_fail++; $display("FAIL notmo_err: got %0d want 0", ne); end
    n_chk++; if (bus.stage !== 2'd1) begin n_fail++; $display("FAIL notmo_stage: got %0d want 1", bus.stage); end
`endif
    bus.arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bus.arm = 1'b0; bus.btn_raw = 5'b0;
    @(negedge clk);
    test_reset;
    test_bounce;
    test_happy;
    test_disarm;
    test_wrong;
    test_simultaneous;
    test_reset_held;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
